// File: rtl/display_scan_if.sv
// Bus between the digit writer and the scan controller: shadow writes, commit
// strobe, and the scan outputs handed to the segment decoder.
interface display_scan_if;
  // wr_en and commit are single-cycle strobes that are always accepted, so
  // there is no ready signal. commit_pending reports that a commit is waiting
  // for the next frame boundary. choose/display_data are valid every cycle.
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [5:0] wr_data;
  logic [7:0] en_mask;
  logic [7:0] blink_mask;
  logic       commit;
  logic       commit_pending;
  logic       frame_done;
  logic [7:0] choose;
  logic [5:0] display_data;
  logic [1:0] dbg_state;
  logic [2:0] dbg_idx;

  modport master (
    output wr_en, wr_addr, wr_data, en_mask, blink_mask, commit,
    input  commit_pending, frame_done, choose, display_data, dbg_state, dbg_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, en_mask, blink_mask, commit,
    output commit_pending, frame_done, choose, display_data, dbg_state, dbg_idx
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Eight-digit time-multiplexed display scanner with a double-buffered frame,
// per-digit enable/blink masks and tear-free updates at frame boundaries.
module display_scan_ctrl #(
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 62
) (
  input logic             clk,
  input logic             rst_n,
  display_scan_if.slave   bus
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int FR_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [FR_W-1:0]  FRAME_LAST = FR_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_SHOW  = 2'd1
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FR_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  logic [5:0]       shadow_q [8];
  logic [5:0]       shadow_d [8];
  logic [5:0]       active_q [8];
  logic [5:0]       active_d [8];
  logic [7:0]       pend_en_q, pend_en_d;
  logic [7:0]       pend_blink_q, pend_blink_d;
  logic [7:0]       act_en_q, act_en_d;
  logic [7:0]       act_blink_q, act_blink_d;
  logic             commit_pending_q, commit_pending_d;

  logic             frame_done_q, frame_done_d;
  logic [7:0]       choose_q, choose_d;
  logic [5:0]       display_data_q, display_data_d;

  logic             blank_end;
  logic             show_end;
  logic             boundary;
  logic             visible;

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    cnt_d            = cnt_q;
    frame_cnt_d      = frame_cnt_q;
    blink_phase_d    = blink_phase_q;
    shadow_d         = shadow_q;
    active_d         = active_q;
    pend_en_d        = pend_en_q;
    pend_blink_d     = pend_blink_q;
    act_en_d         = act_en_q;
    act_blink_d      = act_blink_q;
    commit_pending_d = commit_pending_q;

    blank_end = (state_q == ST_BLANK) && (cnt_q == BLANK_LAST);
    show_end  = (state_q == ST_SHOW)  && (cnt_q == DWELL_LAST);
    boundary  = show_end && (idx_q == 3'd7);

    case (state_q)
      ST_BLANK: begin
        if (blank_end) begin
          cnt_d   = '0;
          state_d = ST_SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (show_end) begin
          cnt_d   = '0;
          state_d = ST_BLANK;
          idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_BLANK;
      end
    endcase

    if (boundary) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
      // A commit landing on the boundary edge defers the whole transfer one frame.
      if (commit_pending_q && !bus.commit) begin
        active_d         = shadow_q;
        act_en_d         = pend_en_q;
        act_blink_d      = pend_blink_q;
        commit_pending_d = 1'b0;
      end
    end

    if (bus.commit) begin
      pend_en_d        = bus.en_mask;
      pend_blink_d     = bus.blink_mask;
      commit_pending_d = 1'b1;
    end

    if (bus.wr_en) begin
      shadow_d[bus.wr_addr] = bus.wr_data;
    end

    // Outputs are computed from next-state so they line up with state/idx.
    visible        = act_en_d[idx_d] && !(act_blink_d[idx_d] && !blink_phase_d);
    choose_d       = ((state_d == ST_SHOW) && visible) ? (8'h01 << idx_d) : 8'h00;
    display_data_d = active_d[idx_d];
    frame_done_d   = (state_d == ST_SHOW) && (idx_d == 3'd7) && (cnt_d == DWELL_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_BLANK;
      idx_q            <= '0;
      cnt_q            <= '0;
      frame_cnt_q      <= '0;
      blink_phase_q    <= 1'b1;
      shadow_q         <= '{default: '0};
      active_q         <= '{default: '0};
      pend_en_q        <= '0;
      pend_blink_q     <= '0;
      act_en_q         <= '0;
      act_blink_q      <= '0;
      commit_pending_q <= 1'b0;
      frame_done_q     <= 1'b0;
      choose_q         <= '0;
      display_data_q   <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      frame_cnt_q      <= frame_cnt_d;
      blink_phase_q    <= blink_phase_d;
      shadow_q         <= shadow_d;
      active_q         <= active_d;
      pend_en_q        <= pend_en_d;
      pend_blink_q     <= pend_blink_d;
      act_en_q         <= act_en_d;
      act_blink_q      <= act_blink_d;
      commit_pending_q <= commit_pending_d;
      frame_done_q     <= frame_done_d;
      choose_q         <= choose_d;
      display_data_q   <= display_data_d;
    end
  end

  assign bus.commit_pending = commit_pending_q;
  assign bus.frame_done     = frame_done_q;
  assign bus.choose         = choose_q;
  assign bus.display_data   = display_data_q;
  assign bus.dbg_state      = state_q;
  assign bus.dbg_idx        = idx_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: randomized writes/commits checked
// against a frame-position model (slot = position / slot length, etc.).
module tb_display_scan_ctrl;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int BF    = 2;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = 8 * SLOT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  display_scan_if bus ();

  display_scan_ctrl #(
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] dut_vec;
  assign dut_vec = {bus.choose, bus.display_data, bus.frame_done, bus.commit_pending};

  // Reference model: pos counts cycles since reset; everything else follows from it.
  int         pos;
  logic [5:0] m_shadow [8];
  logic [5:0] m_active [8];
  logic [7:0] m_en, m_blink, m_pen, m_pbl;
  logic       m_pend;
  logic [7:0] exp_q [$];

  task automatic model_step();
    if (!rst_n) begin
      pos = 0;
      for (int i = 0; i < 8; i++) begin
        m_shadow[i] = '0;
        m_active[i] = '0;
      end
      m_en = '0; m_blink = '0; m_pen = '0; m_pbl = '0; m_pend = 1'b0;
    end else begin
      if ((pos % FRAME) == FRAME - 1 && m_pend && !bus.commit) begin
        for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
        m_en = m_pen; m_blink = m_pbl; m_pend = 1'b0;
      end
      if (bus.commit) begin
        m_pen = bus.en_mask; m_pbl = bus.blink_mask; m_pend = 1'b1;
      end
      if (bus.wr_en) m_shadow[bus.wr_addr] = bus.wr_data;
      pos++;
    end
  endtask

  function automatic logic [15:0] exp_vec();
    int p, slot, frame;
    logic phase;
    logic [7:0] ch;
    p     = pos % FRAME;
    slot  = p / SLOT;
    frame = pos / FRAME;
    phase = ((frame / BF) % 2) == 0;
    ch    = 8'h00;
    if ((p % SLOT) >= BL && m_en[slot] && !(m_blink[slot] && !phase)) ch = 8'h01 << slot;
    return {ch, m_active[slot], (p == FRAME - 1), m_pend};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    bus.wr_en  = 1'b0;
    bus.commit = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int first_done;
    rst_n = 1'b0;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.en_mask = 0; bus.blink_mask = 0; bus.commit = 0;
    repeat (3) tick();
    checks++;
    if (dut_vec !== 16'h0000) begin
      errors++; $display("FAIL reset_outputs got=%h want=0000", dut_vec);
    end
    rst_n = 1'b1;
    first_done = 0;
    for (int c = 1; c <= 2 * FRAME; c++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec() || bus.choose !== 8'h00) begin
        errors++; $display("FAIL reset_idle pos=%0d got=%h want=%h", pos, dut_vec, exp_vec());
      end
      if (bus.frame_done === 1'b1 && first_done == 0) first_done = c + 1;
    end
    checks++;
    if (first_done != FRAME) begin
      errors++; $display("FAIL reset_first_done got=%0d want=%0d", first_done, FRAME);
    end
  endtask

  task automatic test_basic_scan();
    logic [7:0] prev;
    logic [7:0] want;
    int n;
    for (int i = 0; i < 8; i++) begin
      bus.wr_en = 1; bus.wr_addr = 3'(i); bus.wr_data = 6'(i + 1);
      tick();
    end
    bus.en_mask = 8'hFF; bus.blink_mask = 8'h00; bus.commit = 1;
    tick();
    checks++;
    if (bus.commit_pending !== 1'b1) begin
      errors++; $display("FAIL basic_pending got=%b want=1", bus.commit_pending);
    end
    for (n = 0; n < 2 * FRAME && bus.frame_done !== 1'b1; n++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL basic_wait pos=%0d got=%h want=%h", pos, dut_vec, exp_vec());
      end
    end
    checks++;
    if (bus.frame_done !== 1'b1) begin
      errors++; $display("FAIL basic_timeout got=%b want=1", bus.frame_done);
    end
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h01 << i);
    prev = 8'h00;
    for (int c = 0; c < FRAME; c++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL basic_scan pos=%0d got=%h want=%h", pos, dut_vec, exp_vec());
      end
      if (bus.choose !== 8'h00 && bus.choose !== prev) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (bus.choose !== want || bus.display_data !== 6'($clog2(want) + 1)) begin
          errors++;
          $display("FAIL basic_order choose=%h want=%h data=%0d", bus.choose, want, bus.display_data);
        end
      end
      prev = bus.choose;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL basic_left got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_tear_free();
    int hits;
    int n;
    for (n = 0; n < FRAME && (pos % FRAME) != 20; n++) tick();
    bus.wr_en = 1; bus.wr_addr = 3'd3; bus.wr_data = 6'd11;
    tick();
    for (n = 0; n < 2 * FRAME && bus.frame_done !== 1'b1; n++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL tear_wait pos=%0d got=%h want=%h", pos, dut_vec, exp_vec());
      end
    end
    hits = 0;
    for (int c = 0; c < FRAME; c++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL tear_hold pos=%0d got=%h want=%h", pos, dut_vec, exp_vec());
      end
      if (bus.choose === 8'h08 && bus.display_data === 6'd11) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++; $display("FAIL tear_early got=%0d want=0", hits);
    end
    tick();
    bus.en_mask = 8'hFF; bus.blink_mask = 8'h00; bus.commit = 1;
    tick();
    for (n = 0; n < 2 * FRAME && bus.frame_done !== 1'b1; n++) begin
      checks++;
      if (bus.commit_pending !== 1'b1 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL tear_pending pos=%0d got=%h want=%h", pos, dut_vec, exp_vec());
      end
      tick();
    end
    hits = 0;
    for (int c = 0; c < FRAME; c++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL tear_new pos=%0d got=%h want=%h", pos, dut_vec, exp_vec());
      end
      if (bus.choose === 8'h08 && bus.display_data === 6'd11) hits++;
    end
    checks++;
    if (hits != DW) begin
      errors++; $display("FAIL tear_applied got=%0d want=%0d", hits, DW);
    end
  endtask

  task automatic test_boundary_collision();
    int hi;
    int hits;
    int n;
    logic [5:0] new6;
    for (n = 0; n < 2 * FRAME && bus.frame_done !== 1'b1; n++) tick();
    bus.commit = 1; bus.en_mask = 8'h0F; bus.blink_mask = 8'h00;
    bus.wr_en = 1; bus.wr_addr = 3'd2; bus.wr_data = 6'($urandom_range(24, 63));
    tick();
    checks++;
    if (bus.commit_pending !== 1'b1) begin
      errors++; $display("FAIL coll_pending got=%b want=1", bus.commit_pending);
    end
    for (int f = 0; f < 2; f++) begin
      hi = 0;
      for (int c = 0; c < FRAME; c++) begin
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL coll_scan pos=%0d got=%h want=%h", pos, dut_vec, exp_vec());
        end
        if (bus.choose[7:4] !== 4'h0) hi++;
      end
      checks++;
      if (hi != ((f == 0) ? 4 * DW : 0)) begin
        errors++; $display("FAIL coll_upper frame=%0d got=%0d want=%0d", f, hi, (f == 0) ? 4 * DW : 0);
      end
    end
    tick();
    bus.en_mask = 8'hFF; bus.commit = 1;
    tick();
    for (n = 0; n < 2 * FRAME && bus.frame_done !== 1'b1; n++) tick();
    new6 = m_shadow[6] ^ 6'h01;
    bus.wr_en = 1; bus.wr_addr = 3'd6; bus.wr_data = new6;
    tick();
    checks++;
    if (bus.commit_pending !== 1'b0) begin
      errors++; $display("FAIL bwr_pending got=%b want=0", bus.commit_pending);
    end
    hits = 0;
    for (int c = 1; c < FRAME; c++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL bwr_scan pos=%0d got=%h want=%h", pos, dut_vec, exp_vec());
      end
      if (bus.choose === 8'h40 && bus.display_data === new6) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++; $display("FAIL bwr_leak got=%0d want=0", hits);
    end
  endtask

  task automatic test_blink();
    int n;
    int frame;
    int lit4, lit0;
    for (int i = 0; i < 8; i++) begin
      bus.wr_en = 1; bus.wr_addr = 3'(i); bus.wr_data = 6'($urandom_range(0, 23));
      tick();
    end
    bus.en_mask = 8'hFF; bus.blink_mask = 8'h10; bus.commit = 1;
    tick();
    for (n = 0; n < 2 * FRAME && bus.frame_done !== 1'b1; n++) tick();
    for (int f = 0; f < 5; f++) begin
      frame = (pos + 1) / FRAME;
      lit4 = 0; lit0 = 0;
      for (int c = 0; c < FRAME; c++) begin
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL blink_scan pos=%0d got=%h want=%h", pos, dut_vec, exp_vec());
        end
        if (bus.choose === 8'h10) lit4++;
        if (bus.choose === 8'h01) lit0++;
      end
      checks++;
      if (lit4 != ((((frame / BF) % 2) == 0) ? DW : 0) || lit0 != DW) begin
        errors++; $display("FAIL blink_phase frame=%0d lit4=%0d lit0=%0d", frame, lit4, lit0);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 6 * FRAME; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.wr_en = 1; bus.wr_addr = 3'($urandom_range(0, 7)); bus.wr_data = 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 40) == 0) begin
        bus.commit = 1; bus.en_mask = 8'($urandom); bus.blink_mask = 8'($urandom);
      end
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random pos=%0d got=%h want=%h", pos, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    for (n = 0; n < 2 * FRAME && bus.frame_done !== 1'b1; n++) tick();
    tick();
    bus.commit = 1; bus.en_mask = 8'hFF; bus.blink_mask = 8'h00;
    tick();
    for (n = 0; n < FRAME && (pos % FRAME) != 5 * SLOT + BL + 1; n++) tick();
    checks++;
    if (bus.commit_pending !== 1'b1 || bus.choose !== 8'h20) begin
      errors++; $display("FAIL rmid_setup pend=%b choose=%h want 1/20", bus.commit_pending, bus.choose);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (dut_vec !== 16'h0000) begin
      errors++; $display("FAIL rmid_cleared got=%h want=0000", dut_vec);
    end
    for (int c = 0; c < FRAME + 8; c++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec() || bus.choose !== 8'h00) begin
        errors++; $display("FAIL rmid_scan pos=%0d got=%h want=%h", pos, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_boundary_collision();
    test_blink();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
